// File: rtl/ysyx_24100006_lsu.sv
// Load/store unit: one outstanding request, aligned bus access with byte strobes and load extension.
// Optional YSYX_24100006_LSU_MISALIGN_TRAP_EN faults misaligned accesses without touching the bus.
module ysyx_24100006_lsu #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN/8-1:0] mem_wmask,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_resp_err
);

  localparam int unsigned NB     = XLEN / 8;
  localparam int unsigned OFF_W  = $clog2(NB);
  localparam int unsigned SIDX_W = $clog2(XLEN);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;
  state_e state_q, state_d;

  logic              we_q, uns_q, rerr_q;
  logic [1:0]        size_q;
  logic [OFF_W-1:0]  off_q;
  logic [ADDR_W-1:0] addr_q;
  logic [NB-1:0]     wmask_q;
  logic [XLEN-1:0]   wdata_q, rdata_q;

  logic [OFF_W-1:0] req_off;
  logic [3:0]       req_bytes;
  logic [NB-1:0]    req_mask;
  logic             illegal, misalign, fast_err, accept;

  assign req_off   = req_addr[OFF_W-1:0];
  assign req_bytes = 4'd1 << req_size;
  // Bytes past the bus boundary fall off through truncation.
  assign req_mask  = NB'(((16'd1 << req_bytes) - 16'd1) << req_off);
  assign illegal   = (XLEN == 32) && (req_size == 2'd3);
  assign misalign  = (req_off & OFF_W'(req_bytes - 4'd1)) != '0;
`ifdef YSYX_24100006_LSU_MISALIGN_TRAP_EN
  assign fast_err  = illegal || misalign;
`else
  assign fast_err  = illegal;
`endif
  assign accept    = (state_q == StIdle) && req_valid;

  // Load extraction: shift lane into place, keep size bytes, then extend.
  logic [XLEN-1:0]   shifted, keep, load_ext;
  logic [6:0]        nbits;
  logic [SIDX_W-1:0] sign_idx;

  always_comb begin
    shifted  = mem_rdata >> {off_q, 3'b000};
    nbits    = 7'd8 << size_q;
    keep     = ~({XLEN{1'b1}} << nbits);
    sign_idx = SIDX_W'(nbits - 7'd1);
    load_ext = (shifted & keep) | ((shifted[sign_idx] && !uns_q) ? ~keep : '0);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid)      state_d = fast_err ? StResp : StReq;
      StReq:   if (mem_req_ready)  state_d = StWait;
      StWait:  if (mem_resp_valid) state_d = StResp;
      StResp:  if (resp_ready)     state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready     = (state_q == StIdle);
    mem_req_valid = (state_q == StReq);
    resp_valid    = (state_q == StResp);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      rerr_q  <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
      addr_q  <= '0;
      wmask_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        off_q   <= req_off;
        addr_q  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        wmask_q <= req_we ? req_mask : '0;
        wdata_q <= req_wdata << {req_off, 3'b000};
        rdata_q <= '0;
        rerr_q  <= fast_err;
      end
      if ((state_q == StWait) && mem_resp_valid) begin
        rerr_q  <= mem_resp_err;
        rdata_q <= (we_q || mem_resp_err) ? '0 : load_ext;
      end
    end
  end

  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wmask  = wmask_q;
  assign mem_wdata  = wdata_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = rerr_q;

endmodule

// File: tb/tb_ysyx_24100006_lsu.sv
// Directed bench for the LSU: a 32-bit and a 64-bit instance share stimulus, one driven at a time.
module tb_ysyx_24100006_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid32, req_valid64, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, mem_rdata;
  logic        resp_ready, mem_req_ready, mem_resp_valid, mem_resp_err;

  logic        r32_req_ready, r32_resp_valid, r32_resp_err, r32_mem_req_valid, r32_mem_we;
  logic [31:0] r32_resp_rdata, r32_mem_addr, r32_mem_wdata;
  logic [3:0]  r32_mem_wmask;
  logic        r64_req_ready, r64_resp_valid, r64_resp_err, r64_mem_req_valid, r64_mem_we;
  logic [63:0] r64_resp_rdata, r64_mem_wdata;
  logic [31:0] r64_mem_addr;
  logic [7:0]  r64_mem_wmask;

  int checks = 0;
  int errors = 0;
  bit use64 = 1'b0;

  always #5 clk = ~clk;

  ysyx_24100006_lsu #(.XLEN(32), .ADDR_W(32)) u_dut32 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid32), .req_ready(r32_req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .resp_valid(r32_resp_valid), .resp_ready(resp_ready), .resp_rdata(r32_resp_rdata),
    .resp_err(r32_resp_err), .mem_req_valid(r32_mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(r32_mem_we), .mem_addr(r32_mem_addr), .mem_wmask(r32_mem_wmask),
    .mem_wdata(r32_mem_wdata), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata[31:0]),
    .mem_resp_err(mem_resp_err)
  );

  ysyx_24100006_lsu #(.XLEN(64), .ADDR_W(32)) u_dut64 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid64), .req_ready(r64_req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(r64_resp_valid), .resp_ready(resp_ready), .resp_rdata(r64_resp_rdata),
    .resp_err(r64_resp_err), .mem_req_valid(r64_mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(r64_mem_we), .mem_addr(r64_mem_addr), .mem_wmask(r64_mem_wmask),
    .mem_wdata(r64_mem_wdata), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .mem_resp_err(mem_resp_err)
  );

  logic        o_req_ready, o_resp_valid, o_resp_err, o_mem_req_valid, o_mem_we;
  logic [63:0] o_resp_rdata, o_mem_wdata;
  logic [31:0] o_mem_addr;
  logic [7:0]  o_mem_wmask;

  assign o_req_ready     = use64 ? r64_req_ready     : r32_req_ready;
  assign o_resp_valid    = use64 ? r64_resp_valid    : r32_resp_valid;
  assign o_resp_err      = use64 ? r64_resp_err      : r32_resp_err;
  assign o_mem_req_valid = use64 ? r64_mem_req_valid : r32_mem_req_valid;
  assign o_mem_we        = use64 ? r64_mem_we        : r32_mem_we;
  assign o_resp_rdata    = use64 ? r64_resp_rdata    : {32'h0, r32_resp_rdata};
  assign o_mem_wdata     = use64 ? r64_mem_wdata     : {32'h0, r32_mem_wdata};
  assign o_mem_addr      = use64 ? r64_mem_addr      : r32_mem_addr;
  assign o_mem_wmask     = use64 ? r64_mem_wmask     : {4'h0, r32_mem_wmask};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ":req_ready"},     64'(o_req_ready), 64'd1);
    check({tag, ":resp_valid"},    64'(o_resp_valid), 64'd0);
    check({tag, ":resp_err"},      64'(o_resp_err), 64'd0);
    check({tag, ":resp_rdata"},    o_resp_rdata, 64'd0);
    check({tag, ":mem_req_valid"}, 64'(o_mem_req_valid), 64'd0);
    check({tag, ":mem_we"},        64'(o_mem_we), 64'd0);
    check({tag, ":mem_addr"},      64'(o_mem_addr), 64'd0);
    check({tag, ":mem_wmask"},     64'(o_mem_wmask), 64'd0);
    check({tag, ":mem_wdata"},     o_mem_wdata, 64'd0);
  endtask

  // One full transaction with an immediately-ready bus; fast = expect IDLE -> RESP error path.
  task automatic run(input string name, input bit d64, input bit we, input logic [1:0] size,
                     input bit uns, input logic [31:0] addr, input logic [63:0] wdata,
                     input logic [63:0] rdata, input bit berr, input bit fast,
                     input logic [7:0] emask, input logic [63:0] ewdata,
                     input logic [63:0] erdata, input bit eerr);
    logic [31:0] eaddr;
    eaddr = addr & (d64 ? 32'hFFFF_FFF8 : 32'hFFFF_FFFC);
    use64 = d64;
    @(negedge clk);
    check({name, ":req_ready"}, 64'(o_req_ready), 64'd1);
    req_valid32 = !d64; req_valid64 = d64;
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid32 = 1'b0; req_valid64 = 1'b0;
    if (!fast) begin
      check({name, ":mem_req_valid"}, 64'(o_mem_req_valid), 64'd1);
      check({name, ":mem_we"},        64'(o_mem_we), 64'(we));
      check({name, ":mem_addr"},      64'(o_mem_addr), 64'(eaddr));
      check({name, ":mem_wmask"},     64'(o_mem_wmask), 64'(emask));
      check({name, ":mem_wdata"},     o_mem_wdata, ewdata);
      check({name, ":req_ready_busy"}, 64'(o_req_ready), 64'd0);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      check({name, ":mem_req_done"},  64'(o_mem_req_valid), 64'd0);
      check({name, ":resp_early"},    64'(o_resp_valid), 64'd0);
      mem_resp_valid = 1'b1; mem_rdata = rdata; mem_resp_err = berr;
      @(negedge clk);
      mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
    end else begin
      check({name, ":no_mem_req"}, 64'(o_mem_req_valid), 64'd0);
    end
    check({name, ":resp_valid"}, 64'(o_resp_valid), 64'd1);
    check({name, ":resp_rdata"}, o_resp_rdata, erdata);
    check({name, ":resp_err"},   64'(o_resp_err), 64'(eerr));
    check({name, ":req_ready_resp"}, 64'(o_req_ready), 64'd0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({name, ":resp_clear"}, 64'(o_resp_valid), 64'd0);
    check({name, ":back_idle"},  64'(o_req_ready), 64'd1);
  endtask

  initial begin
    reset = 1'b1;
    req_valid32 = 1'b0; req_valid64 = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_rdata = '0; mem_resp_err = 1'b0;
    repeat (2) @(negedge clk);
    use64 = 1'b0; check_idle("rst32");
    use64 = 1'b1; check_idle("rst64");
    reset = 1'b0;

    //   name       d64 we sz uns addr          wdata  rdata  berr fast mask  ewdata  erdata  eerr
    run("st_b32",  0, 1, 0, 0, 32'h8000_0003, 64'hAB, 64'h0, 0, 0, 8'h08, 64'hAB00_0000, 64'h0, 0);
    run("ld_b32s", 0, 0, 0, 0, 32'h8000_0002, 64'h0, 64'h12F0_3456, 0, 0, 8'h00, 64'h0,
        64'hFFFF_FFF0, 0);
    run("ld_b32u", 0, 0, 0, 1, 32'h8000_0002, 64'h0, 64'h12F0_3456, 0, 0, 8'h00, 64'h0,
        64'h0000_00F0, 0);
`ifdef YSYX_24100006_LSU_MISALIGN_TRAP_EN
    run("ld_h_mis", 0, 0, 1, 0, 32'h8000_0001, 64'h0, 64'h12F0_3456, 0, 1, 8'h00, 64'h0,
        64'h0, 1);
`else
    run("ld_h_mis", 0, 0, 1, 0, 32'h8000_0001, 64'h0, 64'h12F0_3456, 0, 0, 8'h00, 64'h0,
        64'hFFFF_F034, 0);
`endif
    run("ld_d32",  0, 0, 3, 0, 32'h8000_0000, 64'h0, 64'h0, 0, 1, 8'h00, 64'h0, 64'h0, 1);
    run("ld_berr", 0, 0, 2, 0, 32'h8000_0010, 64'h0, 64'hDEAD_BEEF, 1, 0, 8'h00, 64'h0,
        64'h0, 1);
    run("st_h32",  0, 1, 1, 0, 32'h8000_0002, 64'hBEEF, 64'h0, 0, 0, 8'h0C, 64'hBEEF_0000,
        64'h0, 0);
    run("st_w64",  1, 1, 2, 0, 32'h8000_0004, 64'h1122_3344, 64'h0, 0, 0, 8'hF0,
        64'h1122_3344_0000_0000, 64'h0, 0);
    run("ld_d64",  1, 0, 3, 0, 32'h8000_0000, 64'h0, 64'h8877_6655_4433_2211, 0, 0, 8'h00,
        64'h0, 64'h8877_6655_4433_2211, 0);
    run("ld_w64s", 1, 0, 2, 0, 32'h8000_0004, 64'h0, 64'h8877_6655_4433_2211, 0, 0, 8'h00,
        64'h0, 64'hFFFF_FFFF_8877_6655, 0);
    run("ld_w64u", 1, 0, 2, 1, 32'h8000_0004, 64'h0, 64'h8877_6655_4433_2211, 0, 0, 8'h00,
        64'h0, 64'h0000_0000_8877_6655, 0);

    // Backpressure on both the bus request and the core response.
    use64 = 1'b0;
    @(negedge clk);
    req_valid32 = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h8000_0008; req_wdata = '0;
    @(negedge clk);
    req_valid32 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("bp:mem_req_valid", 64'(o_mem_req_valid), 64'd1);
      check("bp:mem_addr", 64'(o_mem_addr), 64'h8000_0008);
      check("bp:mem_wmask", 64'(o_mem_wmask), 64'd0);
      check("bp:mem_we", 64'(o_mem_we), 64'd0);
      check("bp:req_ready", 64'(o_req_ready), 64'd0);
      if (i == 3) mem_req_ready = 1'b1;
      @(negedge clk);
    end
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_rdata = 64'hCAFE_F00D;
    @(negedge clk);
    mem_resp_valid = 1'b0; mem_rdata = 64'h0;
    for (int i = 0; i < 3; i++) begin
      check("bp:resp_valid", 64'(o_resp_valid), 64'd1);
      check("bp:resp_rdata", o_resp_rdata, 64'hCAFE_F00D);
      check("bp:req_ready_resp", 64'(o_req_ready), 64'd0);
      if (i == 2) resp_ready = 1'b1;
      @(negedge clk);
    end
    resp_ready = 1'b0;
    check("bp:resp_clear", 64'(o_resp_valid), 64'd0);

    // Reset while waiting on the bus, then a stale response must be ignored.
    @(negedge clk);
    req_valid32 = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h8000_0005;
    req_wdata = 64'h5A;
    @(negedge clk);
    req_valid32 = 1'b0;
    check("rw:mem_wmask", 64'(o_mem_wmask), 64'h2);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle("rw");
    mem_resp_valid = 1'b1; mem_rdata = 64'h1234_5678;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    check("stale:resp_valid", 64'(o_resp_valid), 64'd0);
    check("stale:mem_req_valid", 64'(o_mem_req_valid), 64'd0);
    @(negedge clk);
    check("stale:resp_valid2", 64'(o_resp_valid), 64'd0);
    check("stale:req_ready", 64'(o_req_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
